sensor_request_conditioner: RTL and testbench
=============================================

// Module: sensor_request_conditioner
// PURPOSE
//  Front end for traffic_light_controller. Conditions the five raw vehicle-loop inputs
//  (e_left, e_str, w_left, w_str, ns): synchronises, debounces, and latches each request
//  until that lane is served green. Feeds the controller's *_sensor inputs.
//  Also flags lanes that have waited too long.
// PARAMETERS
//  DEB_CYC   3   consecutive stable synced samples to accept a level change (>=1)
//  MAX_WAIT  20  cycles a latched, unserved request may wait before its starve bit sets
//  WAIT_W    8   wait-counter width; counter saturates at 2**WAIT_W-1 (MAX_WAIT <= that)
// PORTS
//  clk            in   1  system clock, all state on rising edge
//  reset          in   1  synchronous, active-high; clears all state
//  e_left_raw     in   1  raw loop detector, e-bound left (asynchronous)
//  e_str_raw      in   1  raw loop detector, e-bound thru
//  w_left_raw     in   1  raw loop detector, w-bound left
//  w_str_raw      in   1  raw loop detector, w-bound thru
//  ns_raw         in   1  raw loop detector, n-s
//  e_left_light   in   2  colors (light_package) fed back from controller; likewise:
//  e_str_light    in   2  colors
//  w_left_light   in   2  colors
//  w_str_light    in   2  colors
//  ns_light       in   2  colors
//  e_left_sensor  out  1  conditioned request to controller; likewise per lane:
//  e_str_sensor   out  1
//  w_left_sensor  out  1
//  w_str_sensor   out  1
//  ns_sensor      out  1
//  starve         out  5  {ns,w_str,w_left,e_str,e_left}; 1 = waited >= MAX_WAIT cycles
// BEHAVIOUR
//  Five identical lane slices; no cross-lane interaction.
//  Reset: sync1/sync2/deb/latch = 0, debounce cnt = 0, wait cnt = 0
//    -> all *_sensor = 0, starve = 0 on the cycle after reset is sampled high.
//    Reset mid-operation drops pending requests (controller also goes all-red).
//  Sync: raw -> sync1 -> sync2 (2 flops).
//  Debounce:
//    - If sync2 == deb: cnt <= 0.
//    - Else if cnt == DEB_CYC-1: deb <= sync2, cnt <= 0.
//    - Else cnt <= cnt+1.
//    - Any reversion of sync2 before acceptance clears cnt.
//    - Latency: raw edge to deb change = 2+DEB_CYC rising edges if raw is held stable.
//  Latch (green = light input equals colors green):
//    - green: latch <= 0; clear has priority over set in the same cycle.
//    - else if deb: latch <= 1.
//    - else hold.
//  Output: *_sensor = deb | latch (OR of registers only, no other logic).
//    - Vehicle present while green keeps the sensor high, so the controller can extend green.
//    - Vehicle leaving on red/yellow keeps the request high until its green.
//  Yellow counts as not served: a request arriving during yellow stays latched.
//  Wait counter:
//    - Resets to 0 when latch == 0 or light is green.
//    - Else increments by 1 per cycle, saturating at 2**WAIT_W-1 (no wrap).
//  starve[i] = (wait_cnt[i] >= MAX_WAIT), registered compare on the counter value.
//    Starve drops the cycle after green is seen.
//  Light inputs outside the enum (e.g. X or the unused code) are treated as not green.
// TESTING (DEB_CYC=3, MAX_WAIT=20, WAIT_W=8)
//  1. reset=1 for 2 clks with all raw=1 -> all sensors 0, starve 0;
//     release reset -> e_left_sensor rises 5 edges after release.
//  2. ns_raw glitch high for 2 clks, lights red -> ns_sensor never asserts;
//     3-clk pulse -> ns_sensor asserts and stays 1 after raw falls.
//  3. e_str_raw pulse 6 clks, light red -> sensor stays 1;
//     e_str_light=green 1 clk -> sensor 0 the next cycle (raw already low).
//  4. w_left_raw held 1 while w_left_light green 10 clks -> sensor stays 1;
//     raw low -> sensor falls after 5 edges.
//  5. w_str request latched, light red 25 clks -> starve[3]=1 from cycle 21 after latch;
//     green -> starve[3]=0 next cycle.
//  6. Same-cycle set and clear (deb rises while light green) -> latch stays 0,
//     sensor = deb only; wait counter stays 0.

Source files
------------

// File: rtl/sensor_request_conditioner.sv
// Conditions the five raw vehicle-loop inputs for traffic_light_controller.
// Each lane synchronises, debounces and latches its request until served green, and flags long waits.
module sensor_request_conditioner #(
  parameter int         DEB_CYC  = 3,
  parameter int         MAX_WAIT = 20,
  parameter int         WAIT_W   = 8,
  parameter logic [1:0] GREEN    = 2'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       e_left_raw,
  input  logic       e_str_raw,
  input  logic       w_left_raw,
  input  logic       w_str_raw,
  input  logic       ns_raw,
  input  logic [1:0] e_left_light,
  input  logic [1:0] e_str_light,
  input  logic [1:0] w_left_light,
  input  logic [1:0] w_str_light,
  input  logic [1:0] ns_light,
  output logic       e_left_sensor,
  output logic       e_str_sensor,
  output logic       w_left_sensor,
  output logic       w_str_sensor,
  output logic       ns_sensor,
  output logic [4:0] starve
);

  localparam int                LANES     = 5;
  localparam int                CNT_W     = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = '1;
  localparam logic [WAIT_W-1:0] STARVE_AT = WAIT_W'(MAX_WAIT);

  logic [LANES-1:0] rawVec;
  logic [LANES-1:0] greenVec;

  // Lane order everywhere is {ns, w_str, w_left, e_str, e_left}; unknown light codes are not green.
  assign rawVec   = {ns_raw, w_str_raw, w_left_raw, e_str_raw, e_left_raw};
  assign greenVec = {ns_light == GREEN, w_str_light == GREEN, w_left_light == GREEN,
                     e_str_light == GREEN, e_left_light == GREEN};

  logic [LANES-1:0]  sync1_q, sync2_q;
  logic [LANES-1:0]  deb_q, deb_d;
  logic [LANES-1:0]  latch_q, latch_d;
  logic [LANES-1:0]  starve_q, starve_d;
  logic [CNT_W-1:0]  cnt_q  [LANES];
  logic [CNT_W-1:0]  cnt_d  [LANES];
  logic [WAIT_W-1:0] wait_q [LANES];
  logic [WAIT_W-1:0] wait_d [LANES];

  always_comb begin
    deb_d    = deb_q;
    latch_d  = latch_q;
    starve_d = '0;
    for (int i = 0; i < LANES; i++) begin
      cnt_d[i]  = '0;
      wait_d[i] = '0;

      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end

      // Green clears the latch even if a new request is accepted in the same cycle.
      if (greenVec[i]) begin
        latch_d[i] = 1'b0;
      end else if (deb_q[i]) begin
        latch_d[i] = 1'b1;
      end

      if (latch_q[i] && !greenVec[i]) begin
        wait_d[i] = (wait_q[i] == WAIT_SAT) ? wait_q[i] : wait_q[i] + 1'b1;
      end

      // Gated by green so the flag drops on the cycle right after service begins.
      starve_d[i] = !greenVec[i] && (wait_q[i] >= STARVE_AT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      latch_q  <= '0;
      starve_q <= '0;
      cnt_q    <= '{default: '0};
      wait_q   <= '{default: '0};
    end else begin
      sync1_q  <= rawVec;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      latch_q  <= latch_d;
      starve_q <= starve_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
    end
  end

  assign e_left_sensor = deb_q[0] | latch_q[0];
  assign e_str_sensor  = deb_q[1] | latch_q[1];
  assign w_left_sensor = deb_q[2] | latch_q[2];
  assign w_str_sensor  = deb_q[3] | latch_q[3];
  assign ns_sensor     = deb_q[4] | latch_q[4];
  assign starve        = starve_q;

endmodule

// File: tb/tb_sensor_request_conditioner.sv
// Bench for sensor_request_conditioner: directed scenarios followed by random traffic,
// each cycle compared against a request-level reference model.
module tb_sensor_request_conditioner;

  localparam int         DEB_CYC  = 3;
  localparam int         MAX_WAIT = 20;
  localparam int         WAIT_W   = 8;
  localparam logic [1:0] RED      = 2'd0;
  localparam logic [1:0] YELLOW   = 2'd1;
  localparam logic [1:0] GREEN    = 2'd2;
  localparam int         SAT      = (1 << WAIT_W) - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] raw;
  logic [1:0] light [5];
  logic       e_left_sensor, e_str_sensor, w_left_sensor, w_str_sensor, ns_sensor;
  logic [4:0] starve;
  logic [4:0] sensors;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  sensor_request_conditioner #(
    .DEB_CYC(DEB_CYC), .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W), .GREEN(GREEN)
  ) dut (
    .clk(clk), .reset(reset),
    .e_left_raw(raw[0]), .e_str_raw(raw[1]), .w_left_raw(raw[2]),
    .w_str_raw(raw[3]), .ns_raw(raw[4]),
    .e_left_light(light[0]), .e_str_light(light[1]), .w_left_light(light[2]),
    .w_str_light(light[3]), .ns_light(light[4]),
    .e_left_sensor(e_left_sensor), .e_str_sensor(e_str_sensor),
    .w_left_sensor(w_left_sensor), .w_str_sensor(w_str_sensor),
    .ns_sensor(ns_sensor), .starve(starve)
  );

  assign sensors = {ns_sensor, w_str_sensor, w_left_sensor, e_str_sensor, e_left_sensor};

  // Reference model: rawHist holds raw samples seen at each edge (bit 0 newest). The synchroniser
  // makes the debouncer see raw two edges late; a level is accepted once DEB_CYC such delayed
  // samples in a row disagree with the current debounced level.
  logic [15:0] rawHist [5];
  logic        mDeb    [5];
  logic        mPend   [5];
  int          mWaited [5];
  logic [4:0]  mStarve;

  function automatic logic [4:0] modelSensors();
    logic [4:0] s;
    for (int i = 0; i < 5; i++) s[i] = mDeb[i] | mPend[i];
    return s;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        rawHist[i] = '0;
        mDeb[i]    = 1'b0;
        mPend[i]   = 1'b0;
        mWaited[i] = 0;
      end
      mStarve = '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        logic served;
        logic oldDeb;
        bit   allFlip;
        served  = (light[i] == GREEN);
        oldDeb  = mDeb[i];
        allFlip = 1'b1;
        // rawHist[i][k] is the raw value k+1 edges ago; the debouncer now sees raw from 2 edges ago.
        for (int k = 0; k < DEB_CYC; k++)
          if (rawHist[i][k + 1] == oldDeb) allFlip = 1'b0;
        if (allFlip) mDeb[i] = ~oldDeb;
        mStarve[i] = !served && (mWaited[i] >= MAX_WAIT);
        if (served || !mPend[i]) mWaited[i] = 0;
        else if (mWaited[i] < SAT) mWaited[i] = mWaited[i] + 1;
        if (served) mPend[i] = 1'b0;
        else if (oldDeb) mPend[i] = 1'b1;
        rawHist[i] = {rawHist[i][14:0], raw[i]};
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [4:0] gotS, input logic [4:0] expS,
                             input logic [4:0] gotV, input logic [4:0] expV);
    testsRun++;
    assert (gotS === expS) else begin
      testsFailed++;
      $error("FAIL %s sensors observed=%b expected=%b at %0t", tag, gotS, expS, $time);
    end
    testsRun++;
    assert (gotV === expV) else begin
      testsFailed++;
      $error("FAIL %s starve observed=%b expected=%b at %0t", tag, gotV, expV, $time);
    end
  endtask

  task automatic checkBit(input string tag, input int got, input int exp);
    testsRun++;
    assert (got === exp) else begin
      testsFailed++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: inputs change 1 time unit after the edge, outputs are compared there too.
  task automatic applyStimulus(input string tag);
    @(posedge clk);
    #1;
    checkOutput(tag, sensors, modelSensors(), starve, mStarve);
  endtask

  task automatic doReset(input logic [4:0] rawDuring);
    reset = 1'b1;
    raw   = rawDuring;
    for (int i = 0; i < 5; i++) light[i] = RED;
    applyStimulus("reset");
    applyStimulus("reset");
    reset = 1'b0;
    raw   = '0;
  endtask

  initial begin
    int edges;
    bit seen;
    reset = 1'b1;
    raw   = '0;
    for (int i = 0; i < 5; i++) light[i] = RED;

    // Reset with all loops occupied, then latency from release.
    doReset(5'b11111);
    checkOutput("reset_state", sensors, 5'b00000, starve, 5'b00000);
    raw = 5'b00001;
    edges = 0;
    while (e_left_sensor !== 1'b1 && edges < 12) begin
      applyStimulus("release");
      edges++;
    end
    checkBit("e_left_latency", edges, 5);

    // 2-clk glitch is filtered, 3-clk pulse is accepted and latched.
    doReset('0);
    raw[4] = 1'b1;
    applyStimulus("ns_glitch");
    applyStimulus("ns_glitch");
    raw[4] = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus("ns_glitch_wait");
      if (ns_sensor === 1'b1) seen = 1;
    end
    checkBit("ns_glitch_filtered", int'(seen), 0);
    raw[4] = 1'b1;
    for (int k = 0; k < 3; k++) applyStimulus("ns_pulse");
    raw[4] = 1'b0;
    for (int k = 0; k < 10; k++) applyStimulus("ns_pulse_wait");
    checkBit("ns_pulse_latched", int'(ns_sensor), 1);

    // e_str latched on red, cleared by one cycle of green.
    raw[1] = 1'b1;
    for (int k = 0; k < 6; k++) applyStimulus("e_str_pulse");
    raw[1] = 1'b0;
    for (int k = 0; k < 8; k++) applyStimulus("e_str_hold");
    checkBit("e_str_latched", int'(e_str_sensor), 1);
    light[1] = GREEN;
    applyStimulus("e_str_green");
    light[1] = RED;
    checkBit("e_str_served", int'(e_str_sensor), 0);

    // Starvation: flag appears 21 cycles after the latch sets, drops right after green.
    doReset('0);
    raw[3] = 1'b1;
    edges = 0;
    while (w_str_sensor !== 1'b1 && edges < 12) begin
      applyStimulus("w_str_req");
      edges++;
    end
    checkBit("w_str_latency", edges, 5);
    raw[3] = 1'b0;
    for (int k = 0; k < 21; k++) applyStimulus("w_str_wait");
    checkBit("starve_before", int'(starve[3]), 0);
    applyStimulus("w_str_wait");
    checkBit("starve_at_21", int'(starve[3]), 1);
    light[3] = YELLOW;
    for (int k = 0; k < 4; k++) applyStimulus("w_str_yellow");
    checkBit("starve_yellow", int'(starve[3]), 1);
    light[3] = GREEN;
    applyStimulus("w_str_green");
    checkBit("starve_cleared", int'(starve[3]), 0);
    checkBit("w_str_cleared", int'(w_str_sensor), 0);

    // Request rising while green: no latch, sensor follows the debounced level only.
    doReset('0);
    light[2] = GREEN;
    raw[2] = 1'b1;
    for (int k = 0; k < 15; k++) applyStimulus("w_left_green");
    checkBit("w_left_extend", int'(w_left_sensor), 1);
    raw[2] = 1'b0;
    for (int k = 0; k < 5; k++) applyStimulus("w_left_leave");
    checkBit("w_left_fall", int'(w_left_sensor), 0);
    checkBit("w_left_no_starve", int'(starve[2]), 0);

    // Random traffic with occasional unused light code and rare resets.
    doReset('0);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(0, 5) == 0) raw[i] = ~raw[i];
        if ($urandom_range(0, 39) == 0) light[i] = 2'($urandom_range(0, 3));
      end
      reset = ($urandom_range(0, 599) == 0);
      applyStimulus("random");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
